// File: rtl/mips32_pipeline.sv
`default_nettype none
// ============================================================================
// Module  : mips32_pipeline
// Purpose : Five-stage in-order MIPS32 subset core (IF/ID/EX/MEM/WB) with a
//           unified word-addressed instruction/data memory (MEM) and a 32x32
//           register file (REG). There are no interlocks and no forwarding
//           apart from the register file's write-through in ID. Branches
//           resolve in EX and squash the two younger instructions. HLT in WB
//           freezes the core.
// Ports   : clk    - system clock, rising-edge active
//           rst_n  - asynchronous active-low reset
//           halted - high once an HLT has retired (sticky until reset)
// Revision: 1.0 - initial release
// ============================================================================
module mips32_pipeline #(
    parameter int          MEM_DEPTH = 1024,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  wire logic clk,
    input  wire logic rst_n,
    output logic      halted
);
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [5:0] c_op_add   = 6'b000000;
    localparam logic [5:0] c_op_sub   = 6'b000001;
    localparam logic [5:0] c_op_and   = 6'b000010;
    localparam logic [5:0] c_op_or    = 6'b000011;
    localparam logic [5:0] c_op_slt   = 6'b000100;
    localparam logic [5:0] c_op_mul   = 6'b000101;
    localparam logic [5:0] c_op_lw    = 6'b001000;
    localparam logic [5:0] c_op_sw    = 6'b001001;
    localparam logic [5:0] c_op_addi  = 6'b001010;
    localparam logic [5:0] c_op_subi  = 6'b001011;
    localparam logic [5:0] c_op_slti  = 6'b001100;
    localparam logic [5:0] c_op_bneqz = 6'b001101;
    localparam logic [5:0] c_op_beqz  = 6'b001110;
    localparam logic [5:0] c_op_hlt   = 6'b111111;

    // Architectural state (names are fixed so they can be reached hierarchically)
    logic [31:0] MEM [0:MEM_DEPTH-1];
    logic [31:0] REG [0:31];
    logic [31:0] PC;
    logic        HALTED;
    logic        TYPE_BRANCH;

    // Pipeline registers. Decode is done once in ID; later stages carry only
    // the opcode and the destination register (0 means no register write).
    logic [31:0] r_ifid_ir,  r_ifid_npc;
    logic [5:0]  r_idex_op;
    logic [4:0]  r_idex_dst;
    logic [31:0] r_idex_a,   r_idex_b,   r_idex_imm, r_idex_npc;
    logic [5:0]  r_exmem_op;
    logic [4:0]  r_exmem_dst;
    logic [31:0] r_exmem_alu, r_exmem_b;
    logic [5:0]  r_memwb_op;
    logic [4:0]  r_memwb_dst;
    logic [31:0] r_memwb_alu, r_memwb_lmd;

    function automatic logic [AW-1:0] f_wrap(input logic [31:0] addr);
        return AW'(addr % 32'(MEM_DEPTH));
    endfunction

    // ---------------- WB ----------------
    logic        w_wb_hlt, w_stall, w_wb_we;
    logic [31:0] w_wb_data;
    assign w_wb_hlt  = (r_memwb_op == c_op_hlt);
    // The HLT in WB freezes the core on the very edge it retires, so nothing
    // younger (including a store in MEM or a taken branch in EX) takes effect.
    assign w_stall   = HALTED | w_wb_hlt;
    assign w_wb_we   = ~w_stall & (r_memwb_dst != 5'd0);
    assign w_wb_data = (r_memwb_op == c_op_lw) ? r_memwb_lmd : r_memwb_alu;

    // ---------------- ID ----------------
    logic [5:0]  w_id_op;
    logic [4:0]  w_id_rs, w_id_rt, w_id_rd, w_id_dst;
    logic [31:0] w_id_a, w_id_b, w_id_imm;
    assign w_id_op  = r_ifid_ir[31:26];
    assign w_id_rs  = r_ifid_ir[25:21];
    assign w_id_rt  = r_ifid_ir[20:16];
    assign w_id_rd  = r_ifid_ir[15:11];
    assign w_id_imm = {{16{r_ifid_ir[15]}}, r_ifid_ir[15:0]};
    // Register read with write-through from the instruction retiring this cycle
    assign w_id_a = (w_id_rs == 5'd0) ? 32'd0 :
                    (w_wb_we && (r_memwb_dst == w_id_rs)) ? w_wb_data : REG[w_id_rs];
    assign w_id_b = (w_id_rt == 5'd0) ? 32'd0 :
                    (w_wb_we && (r_memwb_dst == w_id_rt)) ? w_wb_data : REG[w_id_rt];

    always_comb begin
        w_id_dst = 5'd0;
        case (w_id_op)
            c_op_add, c_op_sub, c_op_and, c_op_or, c_op_slt, c_op_mul: w_id_dst = w_id_rd;
            c_op_addi, c_op_subi, c_op_slti, c_op_lw:                  w_id_dst = w_id_rt;
            default:                                                    w_id_dst = 5'd0;
        endcase
    end

    // ---------------- EX ----------------
    logic [31:0] w_ex_alu, w_ex_target;
    logic        w_ex_taken;
    always_comb begin
        w_ex_alu = 32'd0;
        case (r_idex_op)
            c_op_add:                  w_ex_alu = r_idex_a + r_idex_b;
            c_op_sub:                  w_ex_alu = r_idex_a - r_idex_b;
            c_op_and:                  w_ex_alu = r_idex_a & r_idex_b;
            c_op_or:                   w_ex_alu = r_idex_a | r_idex_b;
            c_op_slt:                  w_ex_alu = {31'd0, $signed(r_idex_a) < $signed(r_idex_b)};
            c_op_mul:                  w_ex_alu = r_idex_a * r_idex_b;
            c_op_addi, c_op_lw, c_op_sw: w_ex_alu = r_idex_a + r_idex_imm;
            c_op_subi:                 w_ex_alu = r_idex_a - r_idex_imm;
            c_op_slti:                 w_ex_alu = {31'd0, $signed(r_idex_a) < $signed(r_idex_imm)};
            default:                   w_ex_alu = 32'd0;
        endcase
    end
    assign w_ex_taken  = ((r_idex_op == c_op_beqz)  && (r_idex_a == 32'd0)) ||
                         ((r_idex_op == c_op_bneqz) && (r_idex_a != 32'd0));
    assign w_ex_target = r_idex_npc + r_idex_imm;

    // ---------------- MEM / IF memory ports ----------------
    logic [AW-1:0] w_mem_addr;
    logic [31:0]   w_mem_rdata, w_if_ir;
    logic          w_mem_we;
    assign w_mem_addr  = f_wrap(r_exmem_alu);
    assign w_mem_rdata = MEM[w_mem_addr];
    assign w_mem_we    = ~w_stall & (r_exmem_op == c_op_sw);
    assign w_if_ir     = MEM[f_wrap(PC)];

    // Storage arrays are deliberately outside reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) MEM[w_mem_addr]  <= r_exmem_b;
        if (w_wb_we)  REG[r_memwb_dst] <= w_wb_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC          <= RESET_PC;
            HALTED      <= 1'b0;
            TYPE_BRANCH <= 1'b0;
            r_ifid_ir   <= 32'd0;  r_ifid_npc  <= 32'd0;
            r_idex_op   <= 6'd0;   r_idex_dst  <= 5'd0;
            r_idex_a    <= 32'd0;  r_idex_b    <= 32'd0;
            r_idex_imm  <= 32'd0;  r_idex_npc  <= 32'd0;
            r_exmem_op  <= 6'd0;   r_exmem_dst <= 5'd0;
            r_exmem_alu <= 32'd0;  r_exmem_b   <= 32'd0;
            r_memwb_op  <= 6'd0;   r_memwb_dst <= 5'd0;
            r_memwb_alu <= 32'd0;  r_memwb_lmd <= 32'd0;
        end else if (w_stall) begin
            HALTED      <= 1'b1;
            TYPE_BRANCH <= 1'b0;
        end else begin
            TYPE_BRANCH <= w_ex_taken;
            r_exmem_op  <= r_idex_op;   r_exmem_dst <= r_idex_dst;
            r_exmem_alu <= w_ex_alu;    r_exmem_b   <= r_idex_b;
            r_memwb_op  <= r_exmem_op;  r_memwb_dst <= r_exmem_dst;
            r_memwb_alu <= r_exmem_alu; r_memwb_lmd <= w_mem_rdata;
            if (w_ex_taken) begin
                // Redirect and turn the two younger instructions into NOPs
                PC         <= w_ex_target;
                r_ifid_ir  <= 32'd0;  r_ifid_npc <= 32'd0;
                r_idex_op  <= 6'd0;   r_idex_dst <= 5'd0;
                r_idex_a   <= 32'd0;  r_idex_b   <= 32'd0;
                r_idex_imm <= 32'd0;  r_idex_npc <= 32'd0;
            end else begin
                PC         <= PC + 32'd1;
                r_ifid_ir  <= w_if_ir;   r_ifid_npc <= PC + 32'd1;
                r_idex_op  <= w_id_op;   r_idex_dst <= w_id_dst;
                r_idex_a   <= w_id_a;    r_idex_b   <= w_id_b;
                r_idex_imm <= w_id_imm;  r_idex_npc <= r_ifid_npc;
            end
        end
    end

    assign halted = HALTED;

endmodule
`default_nettype wire

// File: tb/tb_mips32_pipeline.sv
`default_nettype none
// ============================================================================
// Module  : tb_mips32_pipeline
// Purpose : Self-checking bench for mips32_pipeline. Loads small directed
//           programs by hierarchy, runs them and compares REG/MEM against a
//           table of hand-computed results, plus hand-written sequences for
//           halt, branch pulse and mid-run reset behaviour.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mips32_pipeline;
    localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_AND = 6'b000010;
    localparam logic [5:0] OP_OR = 6'b000011, OP_SLT = 6'b000100, OP_MUL = 6'b000101;
    localparam logic [5:0] OP_LW = 6'b001000, OP_SW = 6'b001001, OP_ADDI = 6'b001010;
    localparam logic [5:0] OP_SUBI = 6'b001011, OP_SLTI = 6'b001100, OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ = 6'b001110, OP_HLT = 6'b111111;
    localparam logic [31:0] NOP = 32'd0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic halted;
    int   n_pass  = 0;
    int   n_total = 0;
    int   br_cnt  = 0;
    int   b0;

    typedef struct {
        int          prog;
        bit          is_mem;
        int          idx;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    mips32_pipeline #(.MEM_DEPTH(1024), .RESET_PC(32'd0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .halted(halted)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dut.TYPE_BRANCH) br_cnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] enc_r(logic [5:0] op, int rs, int rt, int rd);
        return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction
    function automatic logic [31:0] enc_i(logic [5:0] op, int rs, int rt, int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic void add_vec(int p, bit m, int i, logic [31:0] e);
        vec_t v;
        v.prog = p; v.is_mem = m; v.idx = i; v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Hold reset and load the default image: MEM[k]=k, REG=0
    task automatic begin_prog();
        @(negedge clk);
        rst_n = 1'b0;
        for (int k = 0; k < 1024; k++) dut.MEM[k] = 32'(k);
        for (int r = 0; r < 32; r++) dut.REG[r] = 32'd0;
    endtask
    task automatic release_rst();
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic run_to_halt(input string name, input int maxc);
        int n;
        n = 0;
        while (!halted && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, halted}, 32'd1);
    endtask
    task automatic check_table(input int p);
        foreach (vecs[i]) begin
            if (vecs[i].prog == p) begin
                logic [31:0] act;
                act = vecs[i].is_mem ? dut.MEM[vecs[i].idx] : dut.REG[vecs[i].idx];
                chk($sformatf("prog%0d %s[%0d]", p, vecs[i].is_mem ? "MEM" : "REG", vecs[i].idx),
                    act, vecs[i].exp);
            end
        end
    endtask

    task automatic load_basic();
        dut.MEM[0] = 32'h2801000A;
        dut.MEM[1] = 32'h28020014;
        dut.MEM[2] = 32'h28030019;
        dut.MEM[4] = 32'h00222000;
    endtask

    task automatic load_branch(input logic [5:0] bop);
        dut.MEM[0] = enc_i(OP_ADDI, 0, 1, 0);
        dut.MEM[1] = NOP;
        dut.MEM[2] = NOP;
        dut.MEM[3] = enc_i(bop, 1, 0, 2);
        dut.MEM[4] = enc_i(OP_ADDI, 0, 5, 7);
        dut.MEM[5] = enc_i(OP_ADDI, 0, 6, 8);
        dut.MEM[6] = enc_i(OP_ADDI, 0, 7, 9);
        dut.MEM[7] = enc_i(OP_HLT, 0, 0, 0);
    endtask

    initial begin
        // ---- expected-result table: {program, mem?, index, value} ----
        add_vec(1, 0, 0, 32'd0);  add_vec(1, 0, 1, 32'd10); add_vec(1, 0, 2, 32'd20);
        add_vec(1, 0, 3, 32'd25); add_vec(1, 0, 4, 32'd30); add_vec(1, 0, 5, 32'd0);
        add_vec(1, 0, 6, 32'd0);  add_vec(1, 0, 7, 32'd0);
        add_vec(2, 1, 121, 32'd130); add_vec(2, 0, 2, 32'd130);
        add_vec(2, 1, 200, 32'd200); add_vec(2, 0, 9, 32'd0);
        add_vec(3, 0, 5, 32'd0);  add_vec(3, 0, 6, 32'd0);  add_vec(3, 0, 7, 32'd9);
        add_vec(4, 0, 5, 32'd7);  add_vec(4, 0, 6, 32'd8);  add_vec(4, 0, 7, 32'd9);
        add_vec(5, 0, 0, 32'd0);  add_vec(5, 0, 3, 32'hFFFFFFF1); add_vec(5, 0, 4, 32'd1);
        add_vec(5, 0, 5, 32'd8);  add_vec(5, 0, 6, 32'd5);  add_vec(5, 0, 7, 32'hFFFFFFFD);
        add_vec(5, 0, 8, 32'hFFFFFFFE); add_vec(5, 0, 9, 32'd1); add_vec(5, 0, 10, 32'd0);
        add_vec(6, 0, 1, 32'd10); add_vec(6, 0, 4, 32'd30);

        // ---- program 1: basic ALU, plus reset state ----
        begin_prog();
        load_basic();
        #1;
        chk("reset PC", dut.PC, 32'd0);
        chk("reset halted", {31'd0, halted}, 32'd0);
        chk("reset TYPE_BRANCH", {31'd0, dut.TYPE_BRANCH}, 32'd0);
        release_rst();
        run(20);
        check_table(1);

        // ---- program 2: load/store then HLT; younger SW/ADDI must not commit ----
        begin_prog();
        dut.MEM[0]  = enc_i(OP_ADDI, 0, 1, 120);
        dut.MEM[1]  = NOP; dut.MEM[2] = NOP;
        dut.MEM[3]  = enc_i(OP_LW, 1, 2, 0);
        dut.MEM[4]  = NOP; dut.MEM[5] = NOP;
        dut.MEM[6]  = enc_i(OP_ADDI, 2, 2, 45);
        dut.MEM[7]  = NOP; dut.MEM[8] = NOP;
        dut.MEM[9]  = enc_i(OP_SW, 1, 2, 1);
        dut.MEM[10] = enc_i(OP_HLT, 0, 0, 0);
        dut.MEM[11] = enc_i(OP_SW, 0, 1, 200);
        dut.MEM[12] = enc_i(OP_ADDI, 0, 9, 99);
        dut.MEM[120] = 32'd85;
        release_rst();
        run_to_halt("prog2 halted", 100);
        // HLT at 10 retires with PC pointing four words past it
        chk("prog2 PC at halt", dut.PC, 32'd14);
        run(10);
        chk("prog2 PC held", dut.PC, 32'd14);
        chk("prog2 still halted", {31'd0, halted}, 32'd1);
        check_table(2);

        // ---- program 3: taken BEQZ squashes two younger instructions ----
        begin_prog();
        load_branch(OP_BEQZ);
        b0 = br_cnt;
        release_rst();
        run_to_halt("prog3 halted", 100);
        chk("prog3 TYPE_BRANCH cycles", 32'(br_cnt - b0), 32'd1);
        check_table(3);

        // ---- program 4: not-taken BNEQZ on R1=0 ----
        begin_prog();
        load_branch(OP_BNEQZ);
        b0 = br_cnt;
        release_rst();
        run_to_halt("prog4 halted", 100);
        chk("prog4 TYPE_BRANCH cycles", 32'(br_cnt - b0), 32'd0);
        check_table(4);

        // ---- program 5: MUL/SLT/SUB/AND/OR/SUBI/SLTI, R0 write, unknown opcode ----
        begin_prog();
        dut.MEM[0]  = enc_i(OP_ADDI, 0, 1, 5);
        dut.MEM[1]  = enc_i(OP_ADDI, 0, 2, -3);
        dut.MEM[2]  = NOP; dut.MEM[3] = NOP;
        dut.MEM[4]  = enc_r(OP_MUL, 1, 2, 3);
        dut.MEM[5]  = enc_r(OP_SLT, 2, 1, 4);
        dut.MEM[6]  = enc_r(OP_SUB, 1, 2, 5);
        dut.MEM[7]  = enc_i(OP_ADDI, 0, 0, 5);
        dut.MEM[8]  = enc_r(OP_AND, 1, 2, 6);
        dut.MEM[9]  = enc_r(OP_OR, 1, 2, 7);
        dut.MEM[10] = enc_i(OP_SUBI, 1, 8, 7);
        dut.MEM[11] = enc_i(OP_SLTI, 2, 9, -2);
        dut.MEM[12] = enc_i(6'b010000, 0, 10, 77);
        dut.MEM[13] = enc_i(OP_HLT, 0, 0, 0);
        release_rst();
        run_to_halt("prog5 halted", 100);
        check_table(5);

        // ---- program 6: asynchronous reset mid-run, then re-execution ----
        begin_prog();
        load_basic();
        release_rst();
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset PC", dut.PC, 32'd0);
        chk("midreset halted", {31'd0, halted}, 32'd0);
        chk("midreset R1 kept", dut.REG[1], 32'd10);
        chk("midreset R3 kept", dut.REG[3], 32'd25);
        for (int r = 1; r < 5; r++) dut.REG[r] = 32'd0;
        release_rst();
        run(20);
        check_table(6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
